// File: rtl/object_renderer_pkg.sv
// Shared types for object_renderer: register field codes, the per-object record and colour width helpers.
// Coordinate and colour fields are sized for the largest legal configuration; unused upper bits stay zero.
package object_renderer_pkg;

    localparam int COORD_MAX_W = 16;
    localparam int COLOR_MAX_W = 9;

    typedef enum logic [2:0] {
        FLD_X     = 3'd0,
        FLD_Y     = 3'd1,
        FLD_W     = 3'd2,
        FLD_H     = 3'd3,
        FLD_COLOR = 3'd4,
        FLD_EN    = 3'd5
    } field_e;

    typedef struct packed {
        logic [COORD_MAX_W-1:0] x;
        logic [COORD_MAX_W-1:0] y;
        logic [COORD_MAX_W-1:0] w;
        logic [COORD_MAX_W-1:0] h;
        logic [COLOR_MAX_W-1:0] color;
        logic                   en;
    } object_t;

    function automatic int rgb_width(input int color_w);
        return 3 * color_w;
    endfunction

    function automatic logic [COLOR_MAX_W-1:0] color_mask(input int color_w);
        return (COLOR_MAX_W'(1) << rgb_width(color_w)) - COLOR_MAX_W'(1);
    endfunction

endpackage

// File: rtl/object_renderer_object_hit.sv
// Combinational single-rectangle range test; the end coordinate is formed one bit wider so X+W never wraps.
module object_hit
    import object_renderer_pkg::*;
(
    input  logic [COORD_MAX_W-1:0] pixel_x,
    input  logic [COORD_MAX_W-1:0] pixel_y,
    input  object_t                obj,
    output logic                   hit
);

    logic [COORD_MAX_W:0] x_end;
    logic [COORD_MAX_W:0] y_end;
    logic                 in_x;
    logic                 in_y;

    assign x_end = {1'b0, obj.x} + {1'b0, obj.w};
    assign y_end = {1'b0, obj.y} + {1'b0, obj.h};

    assign in_x = ({1'b0, pixel_x} >= {1'b0, obj.x}) && ({1'b0, pixel_x} < x_end);
    assign in_y = ({1'b0, pixel_y} >= {1'b0, obj.y}) && ({1'b0, pixel_y} < y_end);

    assign hit = obj.en && in_x && in_y;

endmodule

// File: rtl/object_renderer.sv
// Composites N_OBJ rectangles (lowest index on top) onto the VGA pixel stream through a two-stage pipeline.
// Optional per-object collision flags are built when OBJECT_RENDERER_COLLISION_EN is defined.
module object_renderer
    import object_renderer_pkg::*;
#(
    parameter int                   N_OBJ    = 4,
    parameter int                   COORD_W  = 10,
    parameter int                   COLOR_W  = 1,
    parameter logic [3*COLOR_W-1:0] BG_COLOR = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [COORD_W-1:0]           pixel_x,
    input  logic [COORD_W-1:0]           pixel_y,
    input  logic                         in_display,
    input  logic                         frame_start,
    input  logic                         cfg_we,
    input  logic [$clog2(N_OBJ)+2:0]     cfg_addr,
    input  logic [COORD_W-1:0]           cfg_wdata,
    output logic [3*COLOR_W-1:0]         rgb_out,
    output logic                         pix_valid,
    output logic [N_OBJ-1:0]             hit_vec,
    output logic [N_OBJ-1:0]             coll_status
);

    localparam int RGB_W = rgb_width(COLOR_W);

    object_t shadow [N_OBJ];
    object_t active [N_OBJ];

    logic [31:0]            addr_ext;
    logic [28:0]            wr_idx;
    logic [2:0]             wr_fld;
    logic [COORD_MAX_W-1:0] wdata_ext;
    logic [COORD_MAX_W-1:0] px_ext;
    logic [COORD_MAX_W-1:0] py_ext;

    assign addr_ext  = 32'(cfg_addr);
    assign wr_idx    = addr_ext[31:3];
    assign wr_fld    = cfg_addr[2:0];
    assign wdata_ext = COORD_MAX_W'(cfg_wdata);
    assign px_ext    = COORD_MAX_W'(pixel_x);
    assign py_ext    = COORD_MAX_W'(pixel_y);

    // Indices beyond N_OBJ match no loop iteration, and fields 6-7 fall to default, so both are dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_OBJ; i++) shadow[i] <= '0;
        end else if (cfg_we) begin
            for (int i = 0; i < N_OBJ; i++) begin
                if (wr_idx == 29'(i)) begin
                    case (wr_fld)
                        FLD_X:     shadow[i].x     <= wdata_ext;
                        FLD_Y:     shadow[i].y     <= wdata_ext;
                        FLD_W:     shadow[i].w     <= wdata_ext;
                        FLD_H:     shadow[i].h     <= wdata_ext;
                        FLD_COLOR: shadow[i].color <= COLOR_MAX_W'(cfg_wdata) & color_mask(COLOR_W);
                        FLD_EN:    shadow[i].en    <= cfg_wdata[0];
                        default:   ;
                    endcase
                end
            end
        end
    end

    // Copy samples the pre-edge shadow, so a coincident write lands one frame later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_OBJ; i++) active[i] <= '0;
        end else if (frame_start) begin
            for (int i = 0; i < N_OBJ; i++) active[i] <= shadow[i];
        end
    end

    logic [N_OBJ-1:0] hit_raw;

    for (genvar g = 0; g < N_OBJ; g++) begin : g_hit
        object_hit u_object_hit (
            .pixel_x (px_ext),
            .pixel_y (py_ext),
            .obj     (active[g]),
            .hit     (hit_raw[g])
        );
    end

    logic [N_OBJ-1:0] hit_s1;
    logic             disp_s1;
    logic [RGB_W-1:0] color_sel;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_s1  <= '0;
            disp_s1 <= 1'b0;
        end else begin
            hit_s1  <= hit_raw;
            disp_s1 <= in_display;
        end
    end

    // Walk from the highest index down so the lowest hitting index wins.
    always_comb begin
        color_sel = BG_COLOR;
        for (int i = N_OBJ - 1; i >= 0; i--) begin
            if (hit_s1[i]) color_sel = RGB_W'(active[i].color);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rgb_out   <= '0;
            pix_valid <= 1'b0;
            hit_vec   <= '0;
        end else begin
            rgb_out   <= disp_s1 ? color_sel : '0;
            pix_valid <= disp_s1;
            hit_vec   <= hit_s1;
        end
    end

`ifdef OBJECT_RENDERER_COLLISION_EN
    logic [N_OBJ-1:0] coll_acc;
    logic [N_OBJ-1:0] coll_new;
    logic             multi_hit;

    assign multi_hit = (hit_vec & (hit_vec - N_OBJ'(1))) != '0;
    assign coll_new  = (pix_valid && multi_hit) ? hit_vec : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            coll_acc    <= '0;
            coll_status <= '0;
        end else if (frame_start) begin
            coll_status <= coll_acc;
            coll_acc    <= coll_new;
        end else begin
            coll_acc    <= coll_acc | coll_new;
        end
    end
`else
    assign coll_status = '0;
`endif

endmodule

// File: tb/tb_object_renderer.sv
// Self-checking bench for object_renderer: a frame-level reference model compared every cycle,
// plus directed probes with hand-computed expected pixels.
module tb_object_renderer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] pixel_x = '0;
    logic [9:0] pixel_y = '0;
    logic       in_display = 1'b0;
    logic       frame_start = 1'b0;
    logic       cfg_we = 1'b0;
    logic [4:0] cfg_addr = '0;
    logic [9:0] cfg_wdata = '0;
    logic [2:0] rgb_out;
    logic       pix_valid;
    logic [3:0] hit_vec;
    logic [3:0] coll_status;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    object_renderer dut (
        .clk         (clk),
        .reset       (rst_n),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .in_display  (in_display),
        .frame_start (frame_start),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .rgb_out     (rgb_out),
        .pix_valid   (pix_valid),
        .hit_vec     (hit_vec),
        .coll_status (coll_status)
    );

    typedef struct { int x; int y; int w; int h; int c; int en; } mobj_t;
    typedef struct { int rgb; int pv; int hit; } mout_t;

    mobj_t m_sh [4];
    mobj_t m_ac [4];
    mout_t p1, p2;
    int    m_acc, m_coll;
    int    nh, nrgb, nb;
    bit    found;

    // Reference model: objects become visible from the frame after they are written.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                m_sh[i] = '{0, 0, 0, 0, 0, 0};
                m_ac[i] = '{0, 0, 0, 0, 0, 0};
            end
            p1 = '{0, 0, 0};
            p2 = '{0, 0, 0};
            m_acc = 0;
            m_coll = 0;
        end else begin
`ifdef OBJECT_RENDERER_COLLISION_EN
            nb = (p2.pv != 0 && $countones(4'(p2.hit)) > 1) ? p2.hit : 0;
            if (frame_start) begin
                m_coll = m_acc;
                m_acc  = nb;
            end else begin
                m_acc = m_acc | nb;
            end
`endif
            nh = 0;
            nrgb = 0;
            found = 0;
            for (int i = 0; i < 4; i++) begin
                if (m_ac[i].en != 0 &&
                    int'(pixel_x) >= m_ac[i].x && int'(pixel_x) < m_ac[i].x + m_ac[i].w &&
                    int'(pixel_y) >= m_ac[i].y && int'(pixel_y) < m_ac[i].y + m_ac[i].h) begin
                    nh = nh | (1 << i);
                    if (!found) begin
                        found = 1;
                        nrgb = m_ac[i].c;
                    end
                end
            end
            if (!in_display) nrgb = 0;
            p2 = p1;
            p1 = '{nrgb, int'(in_display), nh};
            if (frame_start) begin
                for (int i = 0; i < 4; i++) m_ac[i] = m_sh[i];
            end
            if (cfg_we) begin
                case (int'(cfg_addr[2:0]))
                    0: m_sh[cfg_addr[4:3]].x  = int'(cfg_wdata);
                    1: m_sh[cfg_addr[4:3]].y  = int'(cfg_wdata);
                    2: m_sh[cfg_addr[4:3]].w  = int'(cfg_wdata);
                    3: m_sh[cfg_addr[4:3]].h  = int'(cfg_wdata);
                    4: m_sh[cfg_addr[4:3]].c  = int'(cfg_wdata) % 8;
                    5: m_sh[cfg_addr[4:3]].en = int'(cfg_wdata) % 2;
                    default: ;
                endcase
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("cyc_rgb",  int'(rgb_out),     p2.rgb);
        chk("cyc_pv",   int'(pix_valid),   p2.pv);
        chk("cyc_hit",  int'(hit_vec),     p2.hit);
        chk("cyc_coll", int'(coll_status), m_coll);
    end

    task automatic cfg(input int idx, input int fld, input int d);
        @(negedge clk);
        cfg_we    = 1'b1;
        cfg_addr  = 5'((idx << 3) | fld);
        cfg_wdata = 10'(d);
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic set_obj(input int idx, input int x, input int y, input int w, input int h,
                           input int c, input int en);
        cfg(idx, 0, x);
        cfg(idx, 1, y);
        cfg(idx, 2, w);
        cfg(idx, 3, h);
        cfg(idx, 4, c);
        cfg(idx, 5, en);
    endtask

    task automatic frame();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic probe(input string name, input int px, input int py, input bit disp,
                         input int exp_rgb, input int exp_hit);
        @(negedge clk);
        pixel_x    = 10'(px);
        pixel_y    = 10'(py);
        in_display = disp;
        @(negedge clk);
        pixel_x    = '0;
        pixel_y    = '0;
        in_display = 1'b0;
        @(negedge clk);
        chk({name, "_rgb"}, int'(rgb_out), exp_rgb);
        chk({name, "_hit"}, int'(hit_vec), exp_hit);
        chk({name, "_pv"},  int'(pix_valid), int'(disp));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_rgb",  int'(rgb_out), 0);
        chk("rst_pv",   int'(pix_valid), 0);
        chk("rst_hit",  int'(hit_vec), 0);
        chk("rst_coll", int'(coll_status), 0);
        rst_n = 1'b1;

        // Single rectangle, including its inclusive/exclusive edges
        set_obj(0, 100, 100, 300, 100, 7, 1);
        probe("pre_frame", 100, 100, 1, 0, 0);
        frame();
        probe("tl_corner", 100, 100, 1, 7, 1);
        probe("br_corner", 399, 199, 1, 7, 1);
        probe("right_out", 400, 150, 1, 0, 0);
        probe("below_out", 250, 200, 1, 0, 0);

        // Overlap priority
        cfg(0, 4, 4);
        set_obj(1, 100, 100, 100, 100, 2, 1);
        frame();
        probe("overlap", 150, 150, 1, 4, 3);
        cfg(0, 5, 0);
        frame();
        probe("obj0_off", 150, 150, 1, 2, 2);

        // Shadow/active timing
        cfg(0, 5, 1);
        frame();
        probe("overlap2", 150, 150, 1, 4, 3);
        cfg(0, 0, 50);
        probe("midframe_old", 60, 150, 1, 0, 0);
        frame();
        probe("midframe_new", 60, 150, 1, 4, 1);
        @(negedge clk);
        frame_start = 1'b1;
        cfg_we      = 1'b1;
        cfg_addr    = 5'((0 << 3) | 0);
        cfg_wdata   = 10'd200;
        @(negedge clk);
        frame_start = 1'b0;
        cfg_we      = 1'b0;
        probe("coinc_old", 60, 150, 1, 4, 1);
        frame();
        probe("coinc_new_a", 60, 150, 1, 0, 0);
        probe("coinc_new_b", 250, 150, 1, 4, 1);

        // Right-edge object must not wrap to the left
        cfg(0, 5, 0);
        cfg(1, 5, 0);
        set_obj(2, 1000, 0, 100, 1023, 1, 1);
        frame();
        probe("edge_1000", 1000, 10, 1, 1, 4);
        probe("edge_1023", 1023, 10, 1, 1, 4);
        probe("nowrap_0", 0, 10, 1, 0, 0);
        probe("nowrap_75", 75, 10, 1, 0, 0);
        probe("edge_999", 999, 10, 1, 0, 0);
        cfg(2, 6, 0);
        cfg(2, 7, 0);
        frame();
        probe("fld67_ignored", 1000, 10, 1, 1, 4);
        cfg(2, 2, 0);
        frame();
        probe("w_zero", 1000, 10, 1, 0, 0);
        cfg(2, 2, 100);
        frame();

        // Blanking forces black but hit_vec still reports
        probe("blank", 1000, 10, 0, 0, 4);

        // Asynchronous reset mid-line
        @(negedge clk);
        pixel_x = 10'd1010;
        pixel_y = 10'd10;
        in_display = 1'b1;
        repeat (3) @(negedge clk);
        chk("preRst_rgb", int'(rgb_out), 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("asyncRst_rgb", int'(rgb_out), 0);
        chk("asyncRst_pv",  int'(pix_valid), 0);
        chk("asyncRst_hit", int'(hit_vec), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("postRst_rgb", int'(rgb_out), 0);
        chk("postRst_hit", int'(hit_vec), 0);
        in_display = 1'b0;
        set_obj(0, 0, 0, 100, 100, 5, 1);
        probe("postRst_noframe", 10, 10, 1, 0, 0);
        frame();
        probe("postRst_frame", 10, 10, 1, 5, 1);

        // Collision flags
        set_obj(0, 100, 100, 300, 100, 4, 1);
        set_obj(1, 100, 100, 100, 100, 2, 1);
        frame();
        probe("coll_overlap", 150, 150, 1, 4, 3);
        frame();
        @(negedge clk);
`ifdef OBJECT_RENDERER_COLLISION_EN
        chk("coll_set", int'(coll_status), 3);
`else
        chk("coll_off", int'(coll_status), 0);
`endif
        cfg(1, 0, 600);
        frame();
        frame();
        @(negedge clk);
        chk("coll_clear", int'(coll_status), 0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
